// File: rtl/hcsr04_echo_gen_if.sv
// ---------------------------------------------------------------------------
// hcsr04_echo_gen_if
// Signal bundle between an HC-SR04 controller and the echo responder.
//   trig     : trigger pulse from the controller
//   dist_mm  : emulated distance in millimetres (12 bit)
//   obj_en   : 1 = an object is present at dist_mm
//   echo     : echo pulse back to the controller
//   busy     : responder is in a measurement
//   trig_err : one-cycle pulse, trigger was too short
//   done     : one-cycle pulse on the cycle echo falls
// master = controller side, slave = responder side.
// ---------------------------------------------------------------------------
interface hcsr04_echo_gen_if;
  logic        trig;
  logic [11:0] dist_mm;
  logic        obj_en;
  logic        echo;
  logic        busy;
  logic        trig_err;
  logic        done;

  modport master (
    output trig, dist_mm, obj_en,
    input  echo, busy, trig_err, done
  );

  modport slave (
    input  trig, dist_mm, obj_en,
    output echo, busy, trig_err, done
  );
endinterface

// File: rtl/hcsr04_echo_gen.sv
// ---------------------------------------------------------------------------
// hcsr04_echo_gen
// Synthesizable HC-SR04 responder. Validates the trigger width, waits a fixed
// burst delay, then produces an echo pulse whose width encodes the latched
// distance (588 cycles per mm at 100 MHz), followed by a recovery period.
//
// Ports:
//   clk : clock (100 MHz)
//   rst : asynchronous reset, active-low
//   bus : hcsr04_echo_gen_if.slave
//         in  trig, dist_mm, obj_en
//         out echo, busy, trig_err, done (all registered)
//
// Parameters (cycles):
//   TRIG_MIN  minimum accepted trig width
//   BURST_DLY trig fall (first low sample) to echo rise
//   NO_OBJ    echo width when no valid object
//   HOLD      recovery after echo fall before a new trig is accepted
// ---------------------------------------------------------------------------
module hcsr04_echo_gen #(
  parameter int unsigned TRIG_MIN  = 1000,
  parameter int unsigned BURST_DLY = 50000,
  parameter int unsigned NO_OBJ    = 3800000,
  parameter int unsigned HOLD      = 6000000
) (
  input  logic                clk,
  input  logic                rst,
  hcsr04_echo_gen_if.slave    bus
);

  localparam int CNT_W = 23;

  localparam logic [CNT_W-1:0] TRIG_MIN_C  = CNT_W'(TRIG_MIN);
  localparam logic [CNT_W-1:0] BURST_DLY_C = CNT_W'(BURST_DLY);
  localparam logic [CNT_W-1:0] NO_OBJ_C    = CNT_W'(NO_OBJ);
  localparam logic [CNT_W-1:0] HOLD_C      = CNT_W'(HOLD);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG_HI = 3'd1,
    BURST   = 3'd2,
    ECHO    = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   width_p0;
  logic [11:0]        dist_lat;
  logic               obj_lat;
  logic               trig_prev;
  logic               echo_q;
  logic               busy_q;
  logic               trig_err_q;
  logic               done_q;

  // Counter increment that holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}})
      return v;
    else
      return v + 1'b1;
  endfunction

  // Echo width from the latched distance. Out-of-range distances and absent
  // objects both report the no-object width.
  function automatic logic [CNT_W-1:0] echo_width(input logic [11:0] d,
                                                  input logic        o);
    logic [21:0] prod;
    prod = 22'(d) * 22'd588;
    if (o && (d >= 12'd20) && (d <= 12'd4000))
      return {1'b0, prod};
    else
      return NO_OBJ_C;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      width_p0   <= '0;
      dist_lat   <= '0;
      obj_lat    <= 1'b0;
      // Treat trig as already high so a trig held across reset release must
      // be seen low before it can start a measurement.
      trig_prev  <= 1'b1;
      echo_q     <= 1'b0;
      busy_q     <= 1'b0;
      trig_err_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      trig_prev  <= bus.trig;
      trig_err_q <= 1'b0;
      done_q     <= 1'b0;

      unique case (state)
        IDLE: begin
          echo_q <= 1'b0;
          busy_q <= 1'b0;
          if (bus.trig && !trig_prev) begin
            state <= TRIG_HI;
            cnt   <= CNT_W'(1);
          end
        end

        TRIG_HI: begin
          if (bus.trig) begin
            if (cnt < TRIG_MIN_C)
              cnt <= sat_inc(cnt);
          end else if (cnt >= TRIG_MIN_C) begin
            // This edge is the first low sample; the burst counter starts
            // at 1 here so echo rises exactly BURST_DLY edges later.
            state    <= BURST;
            busy_q   <= 1'b1;
            dist_lat <= bus.dist_mm;
            obj_lat  <= bus.obj_en;
            cnt      <= CNT_W'(1);
          end else begin
            state      <= IDLE;
            trig_err_q <= 1'b1;
            cnt        <= '0;
          end
        end

        // ---- burst delay: width is registered off the latched values ----
        BURST: begin
          width_p0 <= echo_width(dist_lat, obj_lat);
          if (cnt >= BURST_DLY_C) begin
            state  <= ECHO;
            echo_q <= 1'b1;
            cnt    <= CNT_W'(1);
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        // ---- echo high for width_p0 edges ----
        ECHO: begin
          if (cnt >= width_p0) begin
            state  <= HOLDOFF;
            echo_q <= 1'b0;
            done_q <= 1'b1;
            cnt    <= CNT_W'(1);
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        // ---- recovery: trig is ignored until back in IDLE ----
        HOLDOFF: begin
          if (cnt >= HOLD_C) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        default: begin
          state  <= IDLE;
          echo_q <= 1'b0;
          busy_q <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

  assign bus.echo     = echo_q;
  assign bus.busy     = busy_q;
  assign bus.trig_err = trig_err_q;
  assign bus.done     = done_q;

endmodule

// File: doc/hcsr04_echo_gen.md
HCSR04_ECHO_GEN -- requirements
Module: hcsr04_echo_gen

Purpose: synthesizable HC-SR04 sensor responder. It accepts trig from the HC-SR04 controller and returns an echo pulse whose width encodes a programmed distance. Used for loopback test and bench stimulus. Clock is 100 MHz (10 ns period).

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- TRIG_MIN, 1000: minimum accepted trig width in cycles (10 us).
- BURST_DLY, 50000: delay in cycles from accepted trig fall to echo rise (500 us).
- NO_OBJ, 3800000: echo width in cycles when no object is present (38 ms).
- HOLD, 6000000: recovery time in cycles after echo fall before a new trig is accepted (60 ms).
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-low.
- trig, in, 1: trigger from controller; same clock domain, no synchronizer.
- dist_mm, in, 12: emulated distance in mm.
- obj_en, in, 1: 1 = object present.
- echo, out, 1: echo pulse to controller.
- busy, out, 1: measurement in progress.
- trig_err, out, 1: one-cycle pulse, trig too short.
- done, out, 1: one-cycle pulse, echo finished.
REQ-003 All outputs SHALL be registered.

Function
REQ-004 States SHALL be IDLE, TRIG_HI, BURST, ECHO and HOLDOFF.
REQ-005 IDLE -> TRIG_HI SHALL occur only on a trig rising edge (trig=1 with the previous sample 0); the trig width counter starts at 1 on that cycle.
REQ-006 In TRIG_HI the width counter SHALL increment each cycle trig=1, saturating at TRIG_MIN.
REQ-007 On the first cycle trig=0 in TRIG_HI:
- counter >= TRIG_MIN: go to BURST, latch dist_mm and obj_en.
- otherwise: trig_err=1 for exactly one cycle, return to IDLE.
REQ-008 echo SHALL rise exactly BURST_DLY cycles after the cycle trig is first sampled low; it SHALL stay high for exactly W cycles and then go to HOLDOFF.
REQ-009 W SHALL be computed from the latched values:
- W = dist_mm*588 if obj_en=1 and 20 <= dist_mm <= 4000.
- W = NO_OBJ otherwise.
- The multiply is unsigned into a 22-bit result; 4000*588 = 2,352,000 does not overflow.
REQ-010 done SHALL pulse for one cycle on the cycle echo falls.
REQ-011 HOLDOFF SHALL last HOLD cycles and then return to IDLE.
REQ-012 trig activity in BURST, ECHO or HOLDOFF SHALL be ignored. A trig already high when IDLE is re-entered SHALL NOT be accepted until it has been seen low.
REQ-013 Changes to dist_mm or obj_en after latching SHALL NOT affect the current measurement.
REQ-014 busy SHALL be 1 exactly in BURST, ECHO and HOLDOFF.
REQ-015 Internal counters SHALL be 23 bits wide, unsigned, and never wrap.

Reset
REQ-016 With rst=0:
- state = IDLE.
- echo, busy, trig_err, done = 0.
- All counters and latched values = 0.
- Previous-trig sample = 1, so a trig high at reset release is not accepted.
REQ-017 Asserting rst mid-operation, in any state, SHALL force echo=0 immediately, without waiting for a clock edge.

Verification
Overrides for all scenarios: TRIG_MIN=1000, BURST_DLY=100, HOLD=1000, NO_OBJ=3800000.
REQ-018 trig high 1000 cycles, dist_mm=100, obj_en=1 -> echo rises 100 cycles after trig fall, stays high 58,800 cycles, done pulses once, busy falls 1000 cycles later.
REQ-019 trig high 999 cycles -> trig_err high exactly 1 cycle, echo=0, busy=0, state returns to IDLE.
REQ-020 Boundary widths:
- dist_mm=20 -> W=11,760.
- dist_mm=4000 -> W=2,352,000.
- dist_mm=19, dist_mm=4001, or obj_en=0 -> W=3,800,000.
REQ-021 Extra trig pulses during ECHO and HOLDOFF -> ignored, echo width unchanged. A trig issued after busy falls -> accepted, new echo produced.
REQ-022 dist_mm changed from 100 to 500 during BURST -> W remains 58,800.
REQ-023 Reset mid-operation:
- rst low mid-ECHO -> echo=0 in the same cycle, busy=0.
- trig held high across rst release -> no measurement until trig falls and rises again.
